// File: rtl/vote_pkg.sv
// Shared state encoding, default widths and the candidate-index width helper
// used by the poll controller and its booth arbiter.
package vote_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        OPEN,
        DRAIN,
        TALLY,
        DONE
    } state_t;

    localparam int DEF_NUM_BOOTHS = 4;
    localparam int DEF_NUM_CAND   = 4;
    localparam int DEF_CNT_W      = 21;

    // Index width for n entries, never narrower than one bit.
    function automatic int cidx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer advances past the winner only on an enabled grant.
module rr_arbiter
    import vote_pkg::*;
#(
    parameter int N = DEF_NUM_BOOTHS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = cidx_w(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = en;
                ptr_next   = PW'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/vote_controller.sv
// Poll lifecycle controller: clears the counter bank, arbitrates booth votes
// into one increment per cycle while open, then scans the counts for a winner.
module vote_controller
    import vote_pkg::*;
#(
    parameter int NUM_BOOTHS = DEF_NUM_BOOTHS,
    parameter int NUM_CAND   = DEF_NUM_CAND,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int CIDX_W    = cidx_w(NUM_CAND)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         open_poll,
    input  logic                         close_poll,
    input  logic [NUM_BOOTHS-1:0]        booth_req,
    input  logic [NUM_BOOTHS*CIDX_W-1:0] booth_cand,
    input  logic [NUM_CAND*CNT_W-1:0]    count_in,
    output logic [NUM_BOOTHS-1:0]        booth_ack,
    output logic [NUM_CAND-1:0]          cnt_up,
    output logic                         cnt_rst,
    output logic                         invalid_vote,
    output logic                         poll_open,
    output logic [CIDX_W-1:0]            winner,
    output logic                         winner_valid,
    output logic                         tie
);

    state_t state, state_next;
    logic [CIDX_W-1:0] step;

    logic                  arb_en;
    logic [NUM_BOOTHS-1:0] grant;
    logic                  vld_p0;
    logic [CIDX_W-1:0]     cand_p0;
    logic                  cand_ok_p0;
    logic [NUM_CAND-1:0]   cand_hot_p0;

    logic [CNT_W-1:0]  cur_count_p0;
    logic [CNT_W-1:0]  max_count_p1;
    logic [CIDX_W-1:0] best_idx_p1;
    logic              tie_flag_p1;

    // close_poll takes the cycle: no grant and no pointer movement.
    assign arb_en = (state == OPEN) && !close_poll;

    rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req   (booth_req),
        .grant (grant)
    );

    assign booth_ack = grant;
    assign vld_p0    = |grant;

    // Stage p0: candidate of the granted booth, decoded to a counter enable
    always_comb begin
        cand_p0 = '0;
        for (int b = 0; b < NUM_BOOTHS; b++) begin
            if (grant[b]) cand_p0 |= booth_cand[b*CIDX_W +: CIDX_W];
        end
        cand_ok_p0  = int'(cand_p0) < NUM_CAND;
        cand_hot_p0 = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            cand_hot_p0[c] = (cand_p0 == CIDX_W'(c));
        end
    end

    always_comb begin
        state_next   = state;
        poll_open    = 1'b0;
        winner_valid = 1'b0;
        case (state)
            IDLE:  if (open_poll) state_next = CLEAR;
            CLEAR: state_next = OPEN;
            OPEN: begin
                poll_open = 1'b1;
                if (close_poll) state_next = DRAIN;
            end
            DRAIN: if (step == CIDX_W'(1)) state_next = TALLY;
            TALLY: if (step == CIDX_W'(NUM_CAND - 1)) state_next = DONE;
            DONE: begin
                winner_valid = 1'b1;
                if (open_poll) state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: registered counter controls; step restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            step         <= '0;
            cnt_up       <= '0;
            cnt_rst      <= 1'b0;
            invalid_vote <= 1'b0;
        end else begin
            state        <= state_next;
            step         <= (state_next != state) ? '0 : step + 1'b1;
            cnt_rst      <= (state == CLEAR);
            cnt_up       <= (vld_p0 && cand_ok_p0) ? cand_hot_p0 : '0;
            invalid_vote <= vld_p0 && !cand_ok_p0;
        end
    end

    assign cur_count_p0 = count_in[int'(step)*CNT_W +: CNT_W];

    // Tally scan: ties keep the lower index; a later strictly larger count clears tie.
    always_ff @(posedge clk) begin
        if (state == TALLY) begin
            if (step == '0 || cur_count_p0 > max_count_p1) begin
                max_count_p1 <= cur_count_p0;
                best_idx_p1  <= step;
            end
            if (step == '0 || cur_count_p0 > max_count_p1) begin
                tie_flag_p1 <= 1'b0;
            end else if (cur_count_p0 == max_count_p1) begin
                tie_flag_p1 <= 1'b1;
            end
        end
    end

    assign winner = winner_valid ? best_idx_p1 : '0;
    assign tie    = winner_valid && tie_flag_p1;

endmodule
